sprite_line_sched: RTL

// Per-scanline scheduler for oam_scanner.
// - On each line_start it resets the scanner via scan_clear, latches the row and

---
 rtl/sprite_line_sched_if.sv | 31 +++
 rtl/sprite_line_sched.sv | 100 ++++++++++
 2 files changed

// File: rtl/sprite_line_sched_if.sv
// Scanner-facing and slot-buffer-facing signals of sprite_line_sched.
// master = scheduler side, slave = oam_scanner / slot buffer side.
interface sprite_line_sched_if #(
  parameter int MAX_LINE_SPRITES = 16
);
  localparam int SLOT_W = $clog2(MAX_LINE_SPRITES);

  logic [7:0]      scan_row;
  logic            scan_clear;
  logic            conf_req;
  logic            conf_ack;
  logic            conf_exists;
  logic            oam_avail;
  logic [6:0]      scan_oam_addr;
  logic            slot_we;
  logic [SLOT_W-1:0] slot_idx;
  logic [5:0]      slot_sprite_id;
  logic [SLOT_W:0] slot_count;

  modport master (
    output scan_row, scan_clear, conf_req,
    output slot_we, slot_idx, slot_sprite_id, slot_count,
    input  conf_ack, conf_exists, oam_avail, scan_oam_addr
  );

  modport slave (
    input  scan_row, scan_clear, conf_req,
    input  slot_we, slot_idx, slot_sprite_id, slot_count,
    output conf_ack, conf_exists, oam_avail, scan_oam_addr
  );
endinterface

// File: rtl/sprite_line_sched.sv
// Per-scanline scheduler: clears oam_scanner, streams conf_req and stores hits in line slots.
// Define SPRITE_OVF_DETECT_EN to keep scanning past a full line and flag overflow.
module sprite_line_sched #(
  parameter int MAX_LINE_SPRITES = 16
) (
  input  logic       clock,
  input  logic       reset_l,
  input  logic       line_start,
  input  logic [7:0] row_in,
  sprite_line_sched_if.master bus,
  output logic       line_done,
  output logic       busy
`ifdef SPRITE_OVF_DETECT_EN
  ,
  output logic       overflow
`endif
);
  localparam int SLOT_W = $clog2(MAX_LINE_SPRITES);
  localparam logic [SLOT_W:0] FULL_COUNT = (SLOT_W+1)'(MAX_LINE_SPRITES);

  typedef enum logic [1:0] {IDLE, CLEAR, SCAN, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [7:0]      scan_row_q;
  logic [SLOT_W:0] count_q;
  logic            done_q;
  logic            full;
  logic            in_scan;
  logic            read_last;
  logic            store_hit;

  assign full      = (count_q == FULL_COUNT);
  assign in_scan   = (state == SCAN);
  assign read_last = !bus.conf_exists && bus.oam_avail;
  // A line_start in the same cycle as an ack aborts the line, so that ack is dropped.
  assign store_hit = in_scan && bus.conf_ack && !full && !line_start;

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  state_next = IDLE;
      CLEAR: state_next = SCAN;
      SCAN: begin
`ifdef SPRITE_OVF_DETECT_EN
        if (read_last) state_next = DONE;
`else
        if (full || read_last) state_next = DONE;
`endif
      end
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (line_start) state_next = CLEAR;
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      scan_row_q <= 8'd0;
      count_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state_next == DONE);
      if (line_start) begin
        scan_row_q <= row_in;
        count_q    <= '0;
      end else if (store_hit) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

`ifdef SPRITE_OVF_DETECT_EN
  // Sticky until the next line: an in-range sprite arrived with every slot taken.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l)                               overflow <= 1'b0;
    else if (line_start)                        overflow <= 1'b0;
    else if (in_scan && bus.conf_ack && full)   overflow <= 1'b1;
  end

  assign bus.conf_req = in_scan && bus.conf_exists;
`else
  assign bus.conf_req = in_scan && bus.conf_exists && !full;
`endif

  assign bus.scan_row       = scan_row_q;
  assign bus.scan_clear     = (state == CLEAR);
  assign bus.slot_we        = store_hit;
  assign bus.slot_idx       = count_q[SLOT_W-1:0];
  // scan_oam_addr has already advanced past the hit, so step back one entry.
  assign bus.slot_sprite_id = 6'(bus.scan_oam_addr - 7'd1);
  assign bus.slot_count     = count_q;
  assign line_done          = done_q;
  assign busy               = (state == CLEAR) || (state == SCAN);
endmodule
